pdh_cmd_dispatcher: RTL
=======================

PDH_CMD_DISPATCHER -- requirements
Module: pdh_cmd_dispatcher

Interface
REQ-001 SHALL have parameter NUM_MODULES, default 4: number of function modules served, range 1..13.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum WAIT-state cycles before abort, range 2..65535.
REQ-003 SHALL have port clk  input  1: system clock, 125 MHz.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port gpio_i  input  32: PS command word; [30:27] cmd, [26:0] data, [31] ignored; asynchronous to clk.
REQ-006 SHALL have port en_o  output  NUM_MODULES: one-hot, single-cycle enable per module.
REQ-007 SHALL have port data_o  output  27: data of the dispatched command, held stable from en_o until the next dispatch.
REQ-008 SHALL have port done_i  input  NUM_MODULES: completion pulse or level per module.
REQ-009 SHALL have port result_i  input  8*NUM_MODULES: per-module 8-bit result; module m uses bits [8m+7:8m].
REQ-010 SHALL have port status_o  output  32: registered status word to the PS.

Function
REQ-011 SHALL pass gpio_i through a two-flop synchronizer before any other use.
REQ-012 SHALL decode cmd codes: 0x0 = IDLE; 0x1..NUM_MODULES = module index cmd-1; 0xE = STROBE; every other code = invalid.
REQ-013 SHALL stage the cmd and data of the most recent synchronized word whose cmd is not STROBE.
REQ-014 SHALL detect a strobe as synchronized cmd == STROBE while the previous synchronized cmd != STROBE.
REQ-015 SHALL implement states S_IDLE, S_ISSUE, S_WAIT and S_REPORT.
REQ-016 SHALL, in S_IDLE on a strobe, move to S_ISSUE for a module cmd and to S_REPORT for an IDLE or invalid cmd.
REQ-017 SHALL, in S_ISSUE, assert en_o[idx] for exactly one cycle, drive data_o with the staged data, and move to S_WAIT.
REQ-018 SHALL, in S_WAIT, sample only done_i[idx]; when it is high, latch result_i for idx and move to S_REPORT.
REQ-019 SHALL ignore done_i in all states other than S_WAIT, including during the en_o cycle.
REQ-020 SHALL, in S_REPORT, update status_o in one cycle and return to S_IDLE.
REQ-021 SHALL assert en_o for the cycle that starts at clock edge 3, where edge 1 is the first edge that samples the STROBE word.
REQ-022 SHALL complete an IDLE cmd with result 0x00 and no enable.
REQ-023 SHALL complete an invalid cmd with result 0x00, no enable, and status_o[13] set.
REQ-024 SHALL, for a strobe detected outside S_IDLE, ignore the strobe and set sticky status_o[15], which clears when the next strobe is accepted.
REQ-025 SHALL define status_o as: [7:0] result; [11:8] cmd echo; [12] busy (state != S_IDLE); [13] invalid; [14] timeout; [15] overrun; [23:16] sequence count; [31:24] zero.
REQ-026 SHALL increment the sequence count once per S_REPORT, wrapping from 255 to 0.
REQ-027 SHALL update bits [14:13] and [7:0] only in S_REPORT, so they always describe the last completed cmd.

Reset
REQ-028 SHALL, with rst_n low at a clock edge, force state to S_IDLE and clear en_o, data_o, status_o, the staged command, the synchronizers and the timeout counter.
REQ-029 SHALL abort any operation in progress on reset, and SHALL NOT treat a STROBE present on gpio_i at reset release as a strobe until it has first been sampled as non-STROBE.

Configuration
REQ-030 SHALL, with DISPATCH_TIMEOUT_EN defined, count S_WAIT cycles and, after TIMEOUT_CYCLES cycles without done_i[idx], move to S_REPORT with result 0xFF and status_o[14] set.
REQ-031 SHALL, without DISPATCH_TIMEOUT_EN, omit the counter, remain in S_WAIT indefinitely, and tie status_o[14] to 0.

Verification
REQ-032 SHALL cover: word 0x08000055 (cmd 1, data 0x55), then 0x70000000 (STROBE), with done_i[0] returned two cycles after en_o and result 0xA5 -> en_o=0001 for one cycle at edge 3, data_o=0x55, status_o[11:0]=0x1A5, sequence count 1.
REQ-033 SHALL cover: cmd 0xB strobed -> en_o stays 0, status_o[13]=1, status_o[7:0]=0x00, sequence count increments.
REQ-034 SHALL cover: a second strobe while in S_WAIT -> no second en_o and status_o[15]=1; the next accepted strobe clears status_o[15].
REQ-035 SHALL cover, with DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=16: done_i held low -> S_REPORT after 16 WAIT cycles, status_o[14]=1, status_o[7:0]=0xFF.
REQ-036 SHALL cover: rst_n low during S_WAIT -> next cycle status_o=0 and en_o=0; a subsequent strobe dispatches normally.
REQ-037 SHALL cover: 256 completed cmds -> sequence count wraps to 0.

Source files
------------

// File: rtl/pdh_cmd_dispatcher.sv
// PS-to-PL command dispatcher: synchronizes a GPIO command word, fires one-cycle enables
// to function modules and reports completion in a status word. DISPATCH_TIMEOUT_EN adds a WAIT timeout.
module pdh_cmd_dispatcher #(
  parameter int NUM_MODULES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              gpio_i,
  output logic [NUM_MODULES-1:0]   en_o,
  output logic [26:0]              data_o,
  input  logic [NUM_MODULES-1:0]   done_i,
  input  logic [8*NUM_MODULES-1:0] result_i,
  output logic [31:0]              status_o
);
  localparam logic [3:0] CMD_STROBE = 4'hE;
  localparam logic [3:0] NUM_MOD_C  = 4'(NUM_MODULES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_e;

  state_e                   state_q, state_d;
  logic [30:0]              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]               vld_q, vld_d;
  logic                     prev_ns_q, prev_ns_d;
  logic [3:0]               stg_cmd_q, stg_cmd_d;
  logic [26:0]              stg_data_q, stg_data_d;
  logic [3:0]               idx_q, idx_d;
  logic [NUM_MODULES-1:0]   en_q, en_d;
  logic [26:0]              data_q, data_d;
  logic [7:0]               lat_res_q, lat_res_d;
  logic [3:0]               lat_cmd_q, lat_cmd_d;
  logic                     lat_inv_q, lat_inv_d, lat_to_q, lat_to_d;
  logic [7:0]               res_q, res_d, seq_q, seq_d;
  logic [3:0]               cmd_q, cmd_d;
  logic                     inv_q, inv_d, to_q, to_d, ovr_q, ovr_d, busy_q, busy_d;
  logic                     strobe, done_sel, timeout_hit, is_module;
  logic [7:0]               res_sel;
  logic [NUM_MODULES-1:0]   en_sel;
  logic [3:0]               sync_cmd;
  logic                     unused_gpio31;

  assign unused_gpio31 = gpio_i[31];
  assign sync_cmd      = sync2_q[30:27];
  // A strobe needs a genuinely sampled non-STROBE word before it; the valid pipe
  // keeps a STROBE held across reset release from firing.
  assign strobe        = prev_ns_q && (sync_cmd == CMD_STROBE);
  assign is_module     = (stg_cmd_q != 4'h0) && (stg_cmd_q <= NUM_MOD_C);

  always_comb begin
    done_sel = 1'b0;
    res_sel  = 8'h00;
    en_sel   = '0;
    for (int m = 0; m < NUM_MODULES; m++) begin
      en_sel[m] = (stg_cmd_q == 4'(m + 1));
      if (idx_q == 4'(m)) begin
        done_sel = done_i[m];
        res_sel  = result_i[8*m +: 8];
      end
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;
  always_comb begin
    tmo_d = 16'd0;
    if (state_q == S_WAIT && !done_sel) tmo_d = tmo_q + 16'd1;
  end
  assign timeout_hit = (state_q == S_WAIT) && !done_sel && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!rst_n) tmo_q <= 16'd0;
    else        tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    sync1_d    = gpio_i[30:0];
    sync2_d    = sync1_q;
    vld_d      = {vld_q[0], 1'b1};
    prev_ns_d  = vld_q[1] && (sync_cmd != CMD_STROBE);
    stg_cmd_d  = stg_cmd_q;
    stg_data_d = stg_data_q;
    if (sync_cmd != CMD_STROBE) begin
      stg_cmd_d  = sync_cmd;
      stg_data_d = sync2_q[26:0];
    end
    state_d   = state_q;
    idx_d     = idx_q;
    en_d      = '0;
    data_d    = data_q;
    lat_res_d = lat_res_q;
    lat_cmd_d = lat_cmd_q;
    lat_inv_d = lat_inv_q;
    lat_to_d  = lat_to_q;
    res_d     = res_q;
    cmd_d     = cmd_q;
    inv_d     = inv_q;
    to_d      = to_q;
    seq_d     = seq_q;
    ovr_d     = ovr_q;
    case (state_q)
      S_IDLE: if (strobe) begin
        ovr_d     = 1'b0;
        lat_cmd_d = stg_cmd_q;
        lat_res_d = 8'h00;
        lat_to_d  = 1'b0;
        lat_inv_d = 1'b0;
        if (is_module) begin
          state_d = S_ISSUE;
          idx_d   = stg_cmd_q - 4'd1;
          en_d    = en_sel;
          data_d  = stg_data_q;
        end else begin
          state_d   = S_REPORT;
          lat_inv_d = (stg_cmd_q != 4'h0);
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done_sel) begin
          lat_res_d = res_sel;
          state_d   = S_REPORT;
        end else if (timeout_hit) begin
          lat_res_d = 8'hFF;
          lat_to_d  = 1'b1;
          state_d   = S_REPORT;
        end
      end
      S_REPORT: begin
        res_d   = lat_res_q;
        cmd_d   = lat_cmd_q;
        inv_d   = lat_inv_q;
        to_d    = lat_to_q;
        seq_d   = seq_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (strobe && state_q != S_IDLE) ovr_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      vld_q      <= '0;
      prev_ns_q  <= 1'b0;
      stg_cmd_q  <= '0;
      stg_data_q <= '0;
      idx_q      <= '0;
      en_q       <= '0;
      data_q     <= '0;
      lat_res_q  <= '0;
      lat_cmd_q  <= '0;
      lat_inv_q  <= 1'b0;
      lat_to_q   <= 1'b0;
      res_q      <= '0;
      cmd_q      <= '0;
      inv_q      <= 1'b0;
      to_q       <= 1'b0;
      seq_q      <= '0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      vld_q      <= vld_d;
      prev_ns_q  <= prev_ns_d;
      stg_cmd_q  <= stg_cmd_d;
      stg_data_q <= stg_data_d;
      idx_q      <= idx_d;
      en_q       <= en_d;
      data_q     <= data_d;
      lat_res_q  <= lat_res_d;
      lat_cmd_q  <= lat_cmd_d;
      lat_inv_q  <= lat_inv_d;
      lat_to_q   <= lat_to_d;
      res_q      <= res_d;
      cmd_q      <= cmd_d;
      inv_q      <= inv_d;
      to_q       <= to_d;
      seq_q      <= seq_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign en_o     = en_q;
  assign data_o   = data_q;
  assign status_o = {8'h00, seq_q, ovr_q, to_q, inv_q, busy_q, cmd_q, res_q};
endmodule
